// File: rtl/deser_pkg.sv
// Shared types and constants for the receive-side deserializer sequencer.
package deser_pkg;

    localparam int DESER_W = 16;
    localparam logic [DESER_W-1:0] DEFAULT_SYNC_WORD = 16'hBC50;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        RECV,
        SCHK
    } rx_state_e;

    typedef struct packed {
        logic               sof;
        logic               eof;
        logic [DESER_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/deser_rx_fifo.sv
// Small synchronous first-word-fall-through FIFO between the sequencer and the link layer.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module deser_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are only observable through the count-qualified head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/deser_rx_ctrl.sv
// Receive sequencer: hunts for the sync word, runs the deserializer, frames words
// with SOF/EOF, re-checks sync after each frame and queues words toward the link.
module deser_rx_ctrl
    import deser_pkg::*;
#(
    parameter int                DATA_W      = DESER_W,
    parameter logic [DATA_W-1:0] SYNC_WORD   = DEFAULT_SYNC_WORD,
    parameter int                FRAME_WORDS = 4,
    parameter int                FIFO_DEPTH  = 4,
    parameter int                MISS_MAX    = 3,
    parameter int                VALID_TMO   = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sdata,
    output logic              des_start,
    input  logic [DATA_W-1:0] des_pdata,
    input  logic              des_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_eof,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              locked,
    output logic              overflow,
    output logic              tmo_err
);

    localparam int WC_W = $clog2(FRAME_WORDS + 1);
    localparam int MC_W = $clog2(MISS_MAX + 1);
    localparam int IC_W = $clog2(VALID_TMO + 1);

    rx_state_e         state;
    rx_state_e         state_next;
    logic [DATA_W-1:0] window;
    logic [WC_W-1:0]   word_cnt;
    logic [MC_W-1:0]   miss_cnt;
    logic [IC_W-1:0]   idle_cnt;

    logic        in_frame;
    logic        sync_hit;
    logic        last_word;
    logic        word_is_sync;
    logic        miss_final;
    logic        tmo_hit;
    logic        sync_chk;
    logic        push_req;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    fifo_entry_t push_entry;
    fifo_entry_t head;

    assign in_frame     = (state == RECV) || (state == SCHK);
    assign sync_hit     = (window == SYNC_WORD);
    assign last_word    = (word_cnt == WC_W'(FRAME_WORDS - 1));
    assign word_is_sync = (des_pdata == SYNC_WORD);
    assign miss_final   = !word_is_sync && (miss_cnt == MC_W'(MISS_MAX - 1));
    assign tmo_hit      = in_frame && !des_valid && (idle_cnt == IC_W'(VALID_TMO - 1));
    assign sync_chk     = enable && (state == SCHK) && des_valid;
    assign fifo_pop     = m_valid && m_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; dropping enable overrides everything else.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = HUNT;
                HUNT: if (sync_hit) state_next = RECV;
                RECV: begin
                    if (tmo_hit) begin
                        state_next = HUNT;
                    end else if (des_valid && last_word) begin
                        state_next = SCHK;
                    end
                end
                SCHK: begin
                    if (tmo_hit) begin
                        state_next = HUNT;
                    end else if (des_valid) begin
                        state_next = (word_is_sync || !miss_final) ? RECV : HUNT;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State-decoded outputs: the deserializer runs for the whole framed phase.
    always_comb begin
        des_start = in_frame;
        push_req  = enable && (state == RECV) && des_valid;
    end

    // Hunt window plus word, miss and idle counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            window   <= '0;
            word_cnt <= '0;
            miss_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            window   <= (state == HUNT) ? {window[DATA_W-2:0], sdata} : '0;
            idle_cnt <= (in_frame && !des_valid) ? idle_cnt + 1'b1 : '0;
            if (push_req) begin
                word_cnt <= last_word ? '0 : word_cnt + 1'b1;
            end else if (state != RECV) begin
                word_cnt <= '0;
            end
            if (sync_chk) begin
                miss_cnt <= (word_is_sync || miss_final) ? '0 : miss_cnt + 1'b1;
            end else if (!in_frame) begin
                miss_cnt <= '0;
            end
        end
    end

    // Lock status and the sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked   <= 1'b0;
            overflow <= 1'b0;
            tmo_err  <= 1'b0;
        end else begin
            if (!enable || tmo_hit) begin
                locked <= 1'b0;
            end else if (sync_chk) begin
                if (word_is_sync) begin
                    locked <= 1'b1;
                end else if (miss_final) begin
                    locked <= 1'b0;
                end
            end
            if (enable && tmo_hit) begin
                tmo_err <= 1'b1;
            end
            if (push_req && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign push_entry = '{sof: (word_cnt == '0), eof: last_word, data: des_pdata};

    deser_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = head.data;
    assign m_sof   = head.sof;
    assign m_eof   = head.eof;

endmodule

// File: tb/tb_deser_rx_ctrl.sv
// Scoreboard bench for deser_rx_ctrl with a behavioural deserializer and a
// word-level protocol model that predicts the framed output stream and flags.
module tb_deser_rx_ctrl;

    localparam int          DW        = 16;
    localparam logic [15:0] SYNC      = 16'hBC50;
    localparam int          FW        = 4;
    localparam int          DEPTH     = 4;
    localparam int          MISS_MAX  = 3;
    localparam int          VALID_TMO = 24;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          sdata;
    logic          des_start;
    logic [DW-1:0] des_pdata;
    logic          des_valid;
    logic [DW-1:0] m_data;
    logic          m_sof;
    logic          m_eof;
    logic          m_valid;
    logic          m_ready;
    logic          locked;
    logic          overflow;
    logic          tmo_err;
    logic          stall;

    int checks;
    int errors;

    logic [17:0] sb_q[$];

    bit mdl_locked;
    bit mdl_ovf;
    bit mdl_hunting;
    bit mdl_hold;
    int mdl_pos;
    int mdl_miss;
    int mdl_occ;

    deser_rx_ctrl #(
        .DATA_W      (DW),
        .SYNC_WORD   (SYNC),
        .FRAME_WORDS (FW),
        .FIFO_DEPTH  (DEPTH),
        .MISS_MAX    (MISS_MAX),
        .VALID_TMO   (VALID_TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .sdata     (sdata),
        .des_start (des_start),
        .des_pdata (des_pdata),
        .des_valid (des_valid),
        .m_data    (m_data),
        .m_sof     (m_sof),
        .m_eof     (m_eof),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .locked    (locked),
        .overflow  (overflow),
        .tmo_err   (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Deserializer model: MSB-first shift while started, one-cycle valid per 16 bits.
    logic [DW-1:0] des_sr;
    int            des_bits;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            des_sr    <= '0;
            des_bits  <= 0;
            des_valid <= 1'b0;
            des_pdata <= '0;
        end else begin
            des_valid <= 1'b0;
            if (des_start && !stall) begin
                des_sr <= {des_sr[DW-2:0], sdata};
                if (des_bits == DW - 1) begin
                    des_valid <= 1'b1;
                    des_pdata <= {des_sr[DW-2:0], sdata};
                    des_bits  <= 0;
                end else begin
                    des_bits <= des_bits + 1;
                end
            end else if (!des_start) begin
                des_bits <= 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Monitor: compares every accepted head word against the oldest prediction.
    always begin
        logic [17:0] exp_e;
        @(negedge clk);
        #1;
        if (!reset && m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL pop_unexpected actual=%0h required=none", {m_sof, m_eof, m_data});
            end else begin
                exp_e = sb_q.pop_front();
                checkOutput("pop_word", {14'd0, m_sof, m_eof, m_data}, {14'd0, exp_e});
            end
        end
    end

    // Word-level protocol model: frame slots, sync slots, miss counting, FIFO capacity when stalled.
    task automatic model_word(input logic [15:0] w);
        if (mdl_hunting) return;
        if (mdl_pos < FW) begin
            if (!mdl_hold || mdl_occ < DEPTH) begin
                sb_q.push_back({(mdl_pos == 0), (mdl_pos == FW - 1), w});
                mdl_occ++;
            end else begin
                mdl_ovf = 1'b1;
            end
            mdl_pos++;
        end else begin
            mdl_pos = 0;
            if (w == SYNC) begin
                mdl_locked = 1'b1;
                mdl_miss   = 0;
            end else begin
                mdl_miss++;
                if (mdl_miss == MISS_MAX) begin
                    mdl_locked  = 1'b0;
                    mdl_hunting = 1'b1;
                    mdl_miss    = 0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic b);
        @(negedge clk);
        sdata = b;
    endtask

    task automatic send_word(input logic [15:0] w);
        bit prev_locked;
        bit prev_ovf;
        prev_locked = mdl_locked;
        prev_ovf    = mdl_ovf;
        model_word(w);
        for (int i = 15; i >= 0; i--) begin
            applyStimulus(w[i]);
            if (i == 13) begin
                #1;
                checkOutput("locked", {31'd0, locked}, {31'd0, prev_locked});
                checkOutput("overflow", {31'd0, overflow}, {31'd0, prev_ovf});
            end
        end
    endtask

    task automatic send_frame();
        for (int j = 0; j < FW; j++) send_word(16'($urandom));
    endtask

    task automatic send_bad();
        logic [15:0] w;
        w = 16'($urandom);
        if (w == SYNC) w = w ^ 16'h0001;
        send_word(w);
    endtask

    // Quiet line, sync word, then the single bit consumed while the match registers.
    task automatic start_hunt();
        logic [15:0] s;
        s = SYNC;
        for (int i = 0; i < 20; i++) applyStimulus(1'b0);
        for (int i = 15; i >= 0; i--) applyStimulus(s[i]);
        applyStimulus(1'b0);
        mdl_pos     = 0;
        mdl_miss    = 0;
        mdl_hunting = 1'b0;
    endtask

    task automatic finish_session(input string tag);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0);
        #1;
        checkOutput({tag, "_locked_end"}, {31'd0, locked}, {31'd0, mdl_locked});
        checkOutput({tag, "_overflow_end"}, {31'd0, overflow}, {31'd0, mdl_ovf});
        @(negedge clk);
        enable     = 1'b0;
        m_ready    = 1'b1;
        mdl_hold   = 1'b0;
        mdl_locked = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0);
        #1;
        checkOutput({tag, "_des_start_off"}, {31'd0, des_start}, 32'd0);
        checkOutput({tag, "_queue_drained"}, sb_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b1;
        sb_q.delete();
        mdl_locked  = 1'b0;
        mdl_ovf     = 1'b0;
        mdl_hunting = 1'b0;
        mdl_hold    = 1'b0;
        mdl_occ     = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        enable   = 1'b0;
        sdata    = 1'b0;
        m_ready  = 1'b1;
        stall    = 1'b0;
        mdl_hold = 1'b0;
        mdl_occ  = 0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_flags", {25'd0, des_start, m_valid, m_sof, m_eof, locked, overflow, tmo_err}, 32'd0);
        checkOutput("reset_data", {16'd0, m_data}, 32'd0);
        do_reset();

        // Directed frame, lock on second sync, random frames, miss handling and lock loss.
        $display("[TB] test: framing and lock");
        enable = 1'b1;
        start_hunt();
        send_word(16'hA5A5);
        send_word(16'h3C3C);
        send_word(16'h0001);
        send_word(16'hFFFF);
        send_word(SYNC);
        for (int f = 0; f < 3; f++) begin
            send_frame();
            send_word(SYNC);
        end
        send_frame(); send_bad();
        send_frame(); send_bad();
        send_frame(); send_word(SYNC);
        send_frame(); send_bad();
        send_frame(); send_bad();
        send_frame(); send_bad();
        send_word(16'h0000);
        send_word(16'h0000);
        #1;
        checkOutput("lost_lock_des_start", {31'd0, des_start}, 32'd0);
        finish_session("t1");

        // Alternating noise must never start the deserializer; sync match timing is exact.
        $display("[TB] test: noise and hunt timing");
        do_reset();
        enable = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'(i % 2 == 0));
            #1;
            if (des_start || m_valid) seen = 1'b1;
        end
        checkOutput("noise_quiet", {31'd0, seen}, 32'd0);
        begin
            logic [15:0] s;
            s = SYNC;
            for (int i = 15; i >= 0; i--) applyStimulus(s[i]);
        end
        applyStimulus(1'b0);
        #1;
        checkOutput("hunt_not_early", {31'd0, des_start}, 32'd0);
        applyStimulus(1'b0);
        #1;
        checkOutput("hunt_fire", {31'd0, des_start}, 32'd1);
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0);
        #1;
        checkOutput("hunt_no_words", {31'd0, m_valid}, 32'd0);

        // Consumer stalled across two frames: first four kept, the rest dropped.
        $display("[TB] test: overflow");
        do_reset();
        m_ready  = 1'b0;
        mdl_hold = 1'b1;
        enable   = 1'b1;
        start_hunt();
        send_frame(); send_word(SYNC);
        send_frame(); send_word(SYNC);
        #1;
        checkOutput("ovf_held_valid", {31'd0, m_valid}, 32'd1);
        finish_session("t4");

        // des_valid stalled mid-frame: abort exactly at the timeout.
        $display("[TB] test: valid timeout");
        do_reset();
        enable = 1'b1;
        start_hunt();
        send_word(16'($urandom));
        send_word(16'($urandom));
        @(negedge clk);
        stall = 1'b1;
        repeat (VALID_TMO) @(negedge clk);
        #1;
        checkOutput("tmo_before", {31'd0, tmo_err}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("tmo_flag", {31'd0, tmo_err}, 32'd1);
        checkOutput("tmo_des_start", {31'd0, des_start}, 32'd0);
        checkOutput("tmo_locked", {31'd0, locked}, 32'd0);
        stall = 1'b0;
        finish_session("t5");

        // Asynchronous reset in the middle of a frame with two words queued.
        $display("[TB] test: reset mid-frame");
        m_ready  = 1'b0;
        mdl_hold = 1'b1;
        mdl_occ  = 0;
        enable   = 1'b1;
        start_hunt();
        send_word(16'($urandom));
        send_word(16'($urandom));
        for (int i = 0; i < 3; i++) applyStimulus(1'b0);
        #1;
        checkOutput("pre_reset_valid", {31'd0, m_valid}, 32'd1);
        checkOutput("tmo_sticky", {31'd0, tmo_err}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        sb_q.delete();
        #1;
        checkOutput("midreset_flags", {25'd0, des_start, m_valid, m_sof, m_eof, locked, overflow, tmo_err}, 32'd0);
        checkOutput("midreset_data", {16'd0, m_data}, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
